ps2_key_scanner: RTL and testbench

PS2_KEY_SCANNER -- requirements
Module: ps2_key_scanner

---
 rtl/ps2_key_scanner_if.sv | 23 ++
 rtl/ps2_key_scanner.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_scanner.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_scanner_if.sv
// PS/2 line inputs and decoded key-event outputs of ps2_key_scanner, bundled as one port.
interface ps2_key_scanner_if #(
  parameter int unsigned NUM_KEYS = 10
);
  logic                ps2_clk;
  logic                ps2_dat;
  logic [NUM_KEYS-1:0] key_down;
  logic                evt_valid;
  logic [7:0]          evt_code;
  logic                evt_ext;
  logic                evt_break;
  logic                frame_err;

  modport slave (
    input  ps2_clk, ps2_dat,
    output key_down, evt_valid, evt_code, evt_ext, evt_break, frame_err
  );

  modport master (
    output ps2_clk, ps2_dat,
    input  key_down, evt_valid, evt_code, evt_ext, evt_break, frame_err
  );
endinterface

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard receiver: synchronise and filter the bus, deframe bytes, decode
// E0/F0 prefixes into key events and track the held state of a table of keys.
module ps2_key_scanner #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned NUM_KEYS    = 10,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h043,
    9'h014, 9'h023, 9'h01B, 9'h01C, 9'h01D
  }
) (
  input  logic               clk,
  input  logic               rst_n,
  ps2_key_scanner_if.slave   bus
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_e;

  logic                clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic                filt_q, filt_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                fall;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic                byte_vld_q, byte_vld_d;
  logic [7:0]          byte_q, byte_d;
  logic                ferr_q, ferr_d;
  dec_state_e          state_q, state_d;
  logic                evt_vld_q, evt_vld_d;
  logic [7:0]          evt_code_q, evt_code_d;
  logic                evt_ext_q, evt_ext_d;
  logic                evt_brk_q, evt_brk_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;

  // Filtered level flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    ferr_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: if (!dat_s2_q) bit_cnt_d = 4'd1;
        4'd9: begin
          par_d     = dat_s2_q;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = '0;
          if ((^{shift_q, par_q}) && dat_s2_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        ferr_d    = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    evt_vld_d  = 1'b0;
    evt_code_d = evt_code_q;
    evt_ext_d  = evt_ext_q;
    evt_brk_d  = evt_brk_q;
    key_down_d = key_down_q;
    if (byte_vld_q) begin
      state_d = IDLE;
      if (byte_q == 8'hE0) begin
        if (state_q == IDLE) state_d = EXT;
      end else if (byte_q == 8'hF0) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else begin
        evt_vld_d  = 1'b1;
        evt_code_d = byte_q;
        evt_ext_d  = (state_q == EXT) || (state_q == EXT_BRK);
        evt_brk_d  = (state_q == BRK) || (state_q == EXT_BRK);
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
          if (KEY_CODES[9*k +: 9] == {evt_ext_d, byte_q}) key_down_d[k] = !evt_brk_d;
        end
      end
    end
    // A line error also drops any pending prefix.
    if (ferr_d) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
      state_q    <= IDLE;
      evt_vld_q  <= 1'b0;
      evt_code_q <= '0;
      evt_ext_q  <= 1'b0;
      evt_brk_q  <= 1'b0;
      key_down_q <= '0;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= bus.ps2_dat;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
      state_q    <= state_d;
      evt_vld_q  <= evt_vld_d;
      evt_code_q <= evt_code_d;
      evt_ext_q  <= evt_ext_d;
      evt_brk_q  <= evt_brk_d;
      key_down_q <= key_down_d;
    end
  end

  assign bus.key_down  = key_down_q;
  assign bus.evt_valid = evt_vld_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_ext   = evt_ext_q;
  assign bus.evt_break = evt_brk_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_key_scanner.sv
// Bench for ps2_key_scanner: two instances with different key tables share one
// PS/2 stimulus; directed table, timeout/glitch/reset sequences, then random frames.
module tb_ps2_key_scanner;
  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 1000;
  localparam int unsigned NK   = 10;
  localparam int unsigned HALF = 20;
  // raw drop -> 2 sync flops -> FILTER_LEN samples -> byte delivery -> event register
  localparam int LAT = FL + 3;
  localparam logic [NK*9-1:0] KEYS_A = {9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h043,
                                        9'h014, 9'h023, 9'h01B, 9'h01C, 9'h01D};
  localparam logic [NK*9-1:0] KEYS_B = {9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h175,
                                        9'h014, 9'h023, 9'h01B, 9'h01C, 9'h175};

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk_r = 1'b1, ps2_dat_r = 1'b1;
  always #5 clk = ~clk;

  ps2_key_scanner_if #(.NUM_KEYS(NK)) bus_a ();
  ps2_key_scanner_if #(.NUM_KEYS(NK)) bus_b ();
  assign bus_a.ps2_clk = ps2_clk_r;
  assign bus_a.ps2_dat = ps2_dat_r;
  assign bus_b.ps2_clk = ps2_clk_r;
  assign bus_b.ps2_dat = ps2_dat_r;

  ps2_key_scanner #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .NUM_KEYS(NK), .KEY_CODES(KEYS_A))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ps2_key_scanner #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .NUM_KEYS(NK), .KEY_CODES(KEYS_B))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int cyc = 0, evt_cnt = 0, evt_cnt_b = 0, err_cnt = 0, last_evt_cyc = 0, stop_cyc = 0;
  int vectors = 0, miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.evt_valid) begin
        evt_cnt++;
        last_evt_cyc = cyc;
      end
      if (bus_b.evt_valid) evt_cnt_b++;
      if (bus_a.frame_err) err_cnt++;
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] b;
    bit bad_par, bad_stop, evt, err;
    logic [7:0] code;
    bit ext, brk;
    logic [NK-1:0] ka, kb;
  } vec_t;
  vec_t tbl[28];

  // reference-model state
  logic [NK-1:0] mka, mkb;
  logic [7:0] mcode;
  bit mext, mbrk, mcext, mcbrk;

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_r = bits[i];
      wait_clks(HALF);
      ps2_clk_r = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_clks(HALF);
      ps2_clk_r = 1'b1;
    end
    ps2_dat_r = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_clks(30);
  endtask

  task automatic check_out(input string tag, input int e0, input int eb0, input int r0,
                           input bit evt, input bit err, input logic [7:0] code,
                           input bit ext, input bit brk, input logic [NK-1:0] ka,
                           input logic [NK-1:0] kb);
    chk({tag, ".evt_a"}, evt_cnt - e0, int'(evt));
    chk({tag, ".evt_b"}, evt_cnt_b - eb0, int'(evt));
    chk({tag, ".err"}, err_cnt - r0, int'(err));
    if (evt) chk({tag, ".latency"}, last_evt_cyc - stop_cyc, LAT);
    chk({tag, ".code"}, int'(bus_a.evt_code), int'(code));
    chk({tag, ".ext"}, int'(bus_a.evt_ext), int'(ext));
    chk({tag, ".brk"}, int'(bus_a.evt_break), int'(brk));
    chk({tag, ".keys_a"}, int'(bus_a.key_down), int'(ka));
    chk({tag, ".keys_b"}, int'(bus_b.key_down), int'(kb));
  endtask

  task automatic model_step(input logic [7:0] b, input bit bad, output bit evt, output bit err);
    evt = 1'b0;
    err = 1'b0;
    if (bad) begin
      err = 1'b1;
      mext = 1'b0;
      mbrk = 1'b0;
    end else if (b == 8'hE0) begin
      if (!mext && !mbrk) mext = 1'b1;
      else begin mext = 1'b0; mbrk = 1'b0; end
    end else if (b == 8'hF0) begin
      if (!mbrk) mbrk = 1'b1;
      else begin mext = 1'b0; mbrk = 1'b0; end
    end else begin
      evt = 1'b1;
      mcode = b;
      mcext = mext;
      mcbrk = mbrk;
      for (int k = 0; k < int'(NK); k++) begin
        if (KEYS_A[9*k +: 9] == {mext, b}) mka[k] = !mbrk;
        if (KEYS_B[9*k +: 9] == {mext, b}) mkb[k] = !mbrk;
      end
      mext = 1'b0;
      mbrk = 1'b0;
    end
  endtask

  initial begin
    int e0, eb0, r0;
    bit me, mr, bp, bs;
    logic [7:0] b;
    logic [7:0] codes[11];
    codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h14, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h5A, 8'h75};

    //          byte  bp bs evt err code  ext brk keys_a   keys_b
    tbl[0]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 0, 0, 10'h001, 10'h000};
    tbl[1]  = '{8'hF0, 0, 0, 0, 0, 8'h1D, 0, 0, 10'h001, 10'h000};
    tbl[2]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 0, 1, 10'h000, 10'h000};
    tbl[3]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0, 10'h002, 10'h002};
    tbl[4]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0, 10'h002, 10'h002};
    tbl[5]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 0, 10'h002, 10'h023};
    tbl[6]  = '{8'hE0, 0, 0, 0, 0, 8'h75, 1, 0, 10'h002, 10'h023};
    tbl[7]  = '{8'hF0, 0, 0, 0, 0, 8'h75, 1, 0, 10'h002, 10'h023};
    tbl[8]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1, 10'h002, 10'h002};
    tbl[9]  = '{8'h75, 0, 0, 1, 0, 8'h75, 0, 0, 10'h002, 10'h002};
    tbl[10] = '{8'h1C, 1, 0, 0, 1, 8'h75, 0, 0, 10'h002, 10'h002};
    tbl[11] = '{8'h1B, 0, 0, 1, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[12] = '{8'h1B, 0, 0, 1, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[13] = '{8'hF0, 0, 0, 0, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[14] = '{8'h23, 0, 0, 1, 0, 8'h23, 0, 1, 10'h006, 10'h006};
    tbl[15] = '{8'hE0, 0, 0, 0, 0, 8'h23, 0, 1, 10'h006, 10'h006};
    tbl[16] = '{8'hE0, 0, 0, 0, 0, 8'h23, 0, 1, 10'h006, 10'h006};
    tbl[17] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0, 10'h006, 10'h006};
    tbl[18] = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0, 10'h006, 10'h006};
    tbl[19] = '{8'h1B, 0, 1, 0, 1, 8'h1C, 0, 0, 10'h006, 10'h006};
    tbl[20] = '{8'h1B, 0, 0, 1, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[21] = '{8'hF0, 0, 0, 0, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[22] = '{8'hF0, 0, 0, 0, 0, 8'h1B, 0, 0, 10'h006, 10'h006};
    tbl[23] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0, 10'h006, 10'h006};
    tbl[24] = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0, 10'h006, 10'h006};
    tbl[25] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 1, 10'h004, 10'h004};
    tbl[26] = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0, 1, 10'h004, 10'h004};
    tbl[27] = '{8'h14, 0, 0, 1, 0, 8'h14, 1, 0, 10'h004, 10'h004};

    wait_clks(5);
    chk("rst.keys_a", int'(bus_a.key_down), 0);
    chk("rst.keys_b", int'(bus_b.key_down), 0);
    chk("rst.evt_valid", int'(bus_a.evt_valid), 0);
    chk("rst.code", int'(bus_a.evt_code), 0);
    chk("rst.ext_brk", int'({bus_a.evt_ext, bus_a.evt_break}), 0);
    chk("rst.frame_err", int'(bus_a.frame_err), 0);
    rst_n = 1'b1;
    wait_clks(5);

    for (int i = 0; i < 28; i++) begin
      e0 = evt_cnt; eb0 = evt_cnt_b; r0 = err_cnt;
      send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      check_out($sformatf("row%0d", i), e0, eb0, r0, tbl[i].evt, tbl[i].err, tbl[i].code,
                tbl[i].ext, tbl[i].brk, tbl[i].ka, tbl[i].kb);
    end

    // partial frame then silence: one timeout error, no earlier
    r0 = err_cnt; e0 = evt_cnt;
    send_bits(11'b000_0001_0110, 5);
    wait_clks(TO - 40);
    chk("timeout.early", err_cnt - r0, 0);
    wait_clks(41);
    chk("timeout.err", err_cnt - r0, 1);
    chk("timeout.evt", evt_cnt - e0, 0);
    e0 = evt_cnt; eb0 = evt_cnt_b; r0 = err_cnt;
    send_frame(8'h5A, 0, 0);
    check_out("after_timeout", e0, eb0, r0, 1, 0, 8'h5A, 0, 0, 10'h204, 10'h204);

    // short low glitch on ps2_clk must not be taken as a start bit
    e0 = evt_cnt; eb0 = evt_cnt_b; r0 = err_cnt;
    ps2_dat_r = 1'b0;
    wait_clks(HALF);
    ps2_clk_r = 1'b0;
    wait_clks(2);
    ps2_clk_r = 1'b1;
    wait_clks(HALF);
    ps2_dat_r = 1'b1;
    wait_clks(HALF);
    send_frame(8'h1C, 0, 0);
    check_out("glitch", e0, eb0, r0, 1, 0, 8'h1C, 0, 0, 10'h206, 10'h206);

    // reset in the middle of a frame
    e0 = evt_cnt; r0 = err_cnt;
    send_bits({2'b10, 8'h1B, 1'b0}, 7);
    wait_clks(5);
    rst_n = 1'b0;
    wait_clks(3);
    chk("midrst.keys_a", int'(bus_a.key_down), 0);
    chk("midrst.keys_b", int'(bus_b.key_down), 0);
    chk("midrst.code", int'(bus_a.evt_code), 0);
    chk("midrst.err", int'(bus_a.frame_err), 0);
    rst_n = 1'b1;
    wait_clks(TO + 50);
    chk("midrst.no_err", err_cnt - r0, 0);
    chk("midrst.no_evt", evt_cnt - e0, 0);

    mka = '0; mkb = '0; mcode = '0; mext = 0; mbrk = 0; mcext = 0; mcbrk = 0;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (i == 0)      b = 8'h1D;
      else if (r < 2)  b = 8'hE0;
      else if (r < 5)  b = 8'hF0;
      else if (r == 5) b = 8'($urandom);
      else             b = codes[$urandom_range(0, 10)];
      bp = (i != 0) && ($urandom_range(0, 19) == 0);
      bs = (i != 0) && ($urandom_range(0, 19) == 0);
      model_step(b, bp | bs, me, mr);
      e0 = evt_cnt; eb0 = evt_cnt_b; r0 = err_cnt;
      send_frame(b, bp, bs);
      check_out($sformatf("rand%0d_%02h", i, b), e0, eb0, r0, me, mr, mcode, mcext, mcbrk,
                mka, mkb);
      if (i == 0) chk("post_rst.key0", int'(bus_a.key_down), 10'h001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
